// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: streams one N-point complex frame into the FFT core's load
// port, pulses fft_start, then waits for fft_done (rising edge) or a timeout.
// Build option: define FFT_LOAD_BITREV_EN to write frames in bit-reversed address order.
module fft_frame_sequencer #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned LOG2_N       = 5,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned DONE_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_real,
  input  logic [DATA_W-1:0] s_imag,
  input  logic              s_last,
  output logic              load_data_write,
  output logic [LOG2_N-1:0] load_data_addr,
  output logic [DATA_W-1:0] data_real_in,
  output logic [DATA_W-1:0] data_imag_in,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              busy,
  output logic              frame_err,
  output logic              timeout_err,
  output logic [15:0]       frame_count
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_PAD   = 2'd1;
  localparam logic [1:0] ST_START = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  localparam int unsigned SC_W = $clog2(START_CYCLES + 1);
  localparam int unsigned WC_W = $clog2(DONE_TIMEOUT + 1);

  localparam logic [LOG2_N-1:0] LAST      = '1;
  localparam logic [SC_W-1:0]   START_END = SC_W'(START_CYCLES);
  localparam logic [WC_W-1:0]   WAIT_END  = WC_W'(DONE_TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [LOG2_N-1:0] count;
  logic [LOG2_N-1:0] count_next;
  logic [LOG2_N-1:0] wr_addr;
  logic [SC_W-1:0]   start_cnt;
  logic [WC_W-1:0]   wait_cnt;
  logic              done_q;
  logic              done_edge;
  logic              accept;

`ifdef FFT_LOAD_BITREV_EN
  function automatic logic [LOG2_N-1:0] bit_reverse(input logic [LOG2_N-1:0] v);
    logic [LOG2_N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2_N; i++) begin
      r[i] = v[LOG2_N-1-i];
    end
    return r;
  endfunction
`endif

  // Handshake, done-edge detection and memory address mapping
  always_comb begin
    accept    = s_valid && s_ready;
    done_edge = fft_done && !done_q;
`ifdef FFT_LOAD_BITREV_EN
    wr_addr = bit_reverse(count);
`else
    wr_addr = count;
`endif
  end

  // Next state and beat counter; the N-1 beat always leaves LOAD so count cannot wrap mid-frame
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      ST_LOAD: begin
        if (accept) begin
          count_next = count + 1'b1;
          if (count == LAST) begin
            state_next = ST_START;
          end else if (s_last) begin
            state_next = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        count_next = count + 1'b1;
        if (count == LAST) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (start_cnt == START_END) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_edge || (wait_cnt == WAIT_END)) begin
          state_next = ST_LOAD;
          count_next = '0;
        end
      end
      default: begin
        state_next = ST_LOAD;
        count_next = '0;
      end
    endcase
  end

  // Registered FSM state, write port, start pulse and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_LOAD;
      count           <= '0;
      start_cnt       <= '0;
      wait_cnt        <= '0;
      done_q          <= 1'b0;
      s_ready         <= 1'b0;
      busy            <= 1'b0;
      load_data_write <= 1'b0;
      load_data_addr  <= '0;
      data_real_in    <= '0;
      data_imag_in    <= '0;
      fft_start       <= 1'b0;
      frame_err       <= 1'b0;
      timeout_err     <= 1'b0;
      frame_count     <= '0;
    end else begin
      state           <= state_next;
      count           <= count_next;
      done_q          <= fft_done;
      // s_ready and busy are looked up from the state being entered so they line up with it
      s_ready         <= (state_next == ST_LOAD);
      busy            <= !((state_next == ST_LOAD) && (count_next == '0));
      load_data_write <= 1'b0;
      frame_err       <= 1'b0;
      fft_start       <= 1'b0;
      case (state)
        ST_LOAD: begin
          start_cnt <= '0;
          if (accept) begin
            load_data_write <= 1'b1;
            load_data_addr  <= wr_addr;
            data_real_in    <= s_real;
            data_imag_in    <= s_imag;
            frame_err       <= (count == LAST) ? !s_last : s_last;
          end
        end
        ST_PAD: begin
          start_cnt       <= '0;
          load_data_write <= 1'b1;
          load_data_addr  <= wr_addr;
          data_real_in    <= '0;
          data_imag_in    <= '0;
        end
        ST_START: begin
          wait_cnt <= '0;
          if (start_cnt != START_END) begin
            fft_start <= 1'b1;
            start_cnt <= start_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (done_edge) begin
            frame_count <= frame_count + 16'd1;
          end else if (wait_cnt == WAIT_END) begin
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          start_cnt <= '0;
        end
      endcase
    end
  end

endmodule
